// File: rtl/clk_divider_pkg.sv
// Shared helpers for the clock divider stages: counter sizing and phase split.
package clk_divider_pkg;

  // Counter width for a divide ratio: clog2(div), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    int unsigned w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

  // Length of the low phase: ceil(div/2), so odd ratios get the longer low phase.
  function automatic int unsigned half(input int unsigned div);
    return (div + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_divider_stage.sv
// One divider stage: a wrapping counter plus a registered output flop.
module clk_divider_stage
  import clk_divider_pkg::*;
#(
  parameter int unsigned DIV = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic div_out_o
);

  localparam int unsigned W    = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] HALF = W'(half(DIV));

  logic [W-1:0] cnt_q, cnt_d;
  logic         div_q, div_d;

  // Next count wraps at DIV-1; output is loaded from the next count so it
  // always equals (cnt_q >= HALF) without any combinational path to the pin.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    div_d = (cnt_d >= HALF);
  end

  // Counter and output flop, reset has priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign div_out_o = div_q;

endmodule

// File: rtl/clk_divider.sv
// Free-running divider producing MCLK (div_a) and a slower clock (div_b).
module clk_divider #(
  parameter int unsigned DIV_A = 8,
  parameter int unsigned DIV_B = 256
) (
  input  logic rst_i,
  input  logic clk_i,
  output logic div_a,
  output logic div_b
);

  if (DIV_A < 2) begin : g_bad_div_a
    $fatal(1, "clk_divider: DIV_A must be at least 2 (got %0d)", DIV_A);
  end
  if (DIV_B < 2) begin : g_bad_div_b
    $fatal(1, "clk_divider: DIV_B must be at least 2 (got %0d)", DIV_B);
  end

  clk_divider_stage #(.DIV(DIV_A)) u_stage_a (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .div_out_o (div_a)
  );

  clk_divider_stage #(.DIV(DIV_B)) u_stage_b (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .div_out_o (div_b)
  );

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider at ratios 8/256, 5/7 and 2/3.
module tb_clk_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a8, b8, a5, b5, a2, b2;

  always #5 clk = ~clk;

  clk_divider #(.DIV_A(8), .DIV_B(256)) dut8 (
    .rst_i(rst), .clk_i(clk), .div_a(a8), .div_b(b8)
  );
  clk_divider #(.DIV_A(5), .DIV_B(7)) dut5 (
    .rst_i(rst), .clk_i(clk), .div_a(a5), .div_b(b5)
  );
  clk_divider #(.DIV_A(2), .DIV_B(3)) dut2 (
    .rst_i(rst), .clk_i(clk), .div_a(a2), .div_b(b2)
  );

  // Hand-written output patterns indexed by edges since release modulo ratio.
  bit exp_a8 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  bit exp_a5 [5] = '{0, 0, 0, 1, 1};
  bit exp_b7 [7] = '{0, 0, 0, 0, 1, 1, 1};
  bit exp_a2 [2] = '{0, 1};
  bit exp_b3 [3] = '{0, 0, 1};

  int checks   = 0;
  int failures = 0;

  int n;           // clk edges since the last reset edge
  logic prev_a8, prev_b8;
  int a_falls;     // div_a falls since the last div_b fall
  int last_rise;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_track;
    n         = 0;
    prev_a8   = 1'b0;
    prev_b8   = 1'b0;
    a_falls   = 0;
    last_rise = -1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      n++;
      check("a8", a8, exp_a8[n % 8]);
      check("b8", b8, ((n % 256) >= 128) ? 1 : 0);
      check("cnt_a8", dut8.u_stage_a.cnt_q, n % 8);
      check("a5", a5, exp_a5[n % 5]);
      check("b5", b5, exp_b7[n % 7]);
      check("a2", a2, exp_a2[n % 2]);
      check("b2", b2, exp_b3[n % 3]);
      if (!prev_a8 && a8) begin
        if (last_rise >= 0) check("per_a8", n - last_rise, 8);
        else                check("first_rise_a8", n, 4);
        last_rise = n;
      end
      if (prev_a8 && !a8) a_falls++;
      if (prev_b8 && !b8) begin
        check("align_fall", (prev_a8 && !a8) ? 1 : 0, 1);
        check("a_per_b", a_falls, 32);
        a_falls = 0;
      end
      prev_a8 = a8;
      prev_b8 = b8;
    end
  endtask

  initial begin
    clear_track();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_a8", a8, 0);
      check("rst_b8", b8, 0);
      check("rst_a5", a5, 0);
      check("rst_a2", a2, 0);
      check("rst_cnt_a", dut8.u_stage_a.cnt_q, 0);
      check("rst_cnt_b", dut8.u_stage_b.cnt_q, 0);
    end

    rst = 1'b0;
    run(526);
    check("pre_rst_cnt_a", dut8.u_stage_a.cnt_q, 6);
    check("pre_rst_a8", a8, 1);

    rst = 1'b1;
    tick();
    check("midrst_a8", a8, 0);
    check("midrst_b8", b8, 0);
    check("midrst_cnt_a", dut8.u_stage_a.cnt_q, 0);
    check("midrst_cnt_b", dut8.u_stage_b.cnt_q, 0);
    clear_track();
    rst = 1'b0;
    run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
